queen_board_encoder: RTL and testbench

- Inverse of the 8-Queen column decoder. Takes a latched 8x8 board where each row holds a one-hot queen position and encodes it back to eight 3-bit column indices, one row per handshake.
- Streams the per-row results to the checker/display path over a valid/ready interface.
- Accumulates a packed position word and flags rows that are not exactly one-hot.

---
 rtl/queen_board_encoder_if.sv | 27 ++
 rtl/queen_board_encoder.sv | 132 +++++++++++++
 tb/tb_queen_board_encoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/queen_board_encoder_if.sv
// Row-result stream from the board encoder to the checker/display path.
// The master presents one encoded row per valid/ready handshake.
interface queen_board_encoder_if #(
    parameter int COLW = 3
);
    logic            col_valid;
    logic            col_ready;
    logic [COLW-1:0] row_idx;
    logic [COLW-1:0] col_idx;
    logic            row_err;

    modport master (
        output col_valid,
        output row_idx,
        output col_idx,
        output row_err,
        input  col_ready
    );

    modport slave (
        input  col_valid,
        input  row_idx,
        input  col_idx,
        input  row_err,
        output col_ready
    );
endinterface

// File: rtl/queen_board_encoder.sv
// Encodes a latched 8x8 one-hot queen board into per-row column indices,
// streams them out one row per handshake and packs them into a position word.
module queen_board_encoder #(
    parameter int ROWS = 8,
    parameter int COLW = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ROWS*ROWS-1:0]   board,
    output logic                   busy,
    output logic                   done,
    output logic [ROWS*COLW-1:0]   positions,
    output logic                   board_ok,
    queen_board_encoder_if.master  col_bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ROWS-1:0] ONE      = ROWS'(1);
    localparam logic [COLW-1:0] LAST_ROW = COLW'(ROWS - 1);

    state_t                 state_reg, state_next;
    logic [COLW-1:0]        row_reg, row_next;
    logic [ROWS*ROWS-1:0]   board_reg, board_next;
    logic [ROWS*COLW-1:0]   positions_reg, positions_next;
    logic                   acc_reg, acc_next;
    logic                   ok_reg, ok_next;

    logic [COLW-1:0]        row_col [ROWS];
    logic [ROWS-1:0]        row_bad;
    logic [COLW-1:0]        cur_col;
    logic                   cur_err;
    logic                   emit;

    // Every latched row is decoded in parallel; the current row is then muxed out.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [ROWS-1:0] row_byte;
        logic [COLW-1:0] enc;

        assign row_byte = board_reg[gi*ROWS +: ROWS];

        // Scanning from the top down leaves the lowest set bit as the winner.
        always_comb begin
            enc = '0;
            for (int c = ROWS - 1; c >= 0; c--) begin
                if (row_byte[c]) begin
                    enc = COLW'(c);
                end
            end
        end

        assign row_col[gi] = enc;
        assign row_bad[gi] = (row_byte == '0) || ((row_byte & (row_byte - ONE)) != '0);
    end

    assign cur_col = row_col[row_reg];
    assign cur_err = row_bad[row_reg];
    assign emit    = (state_reg == EMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            board_reg     <= '0;
            positions_reg <= '0;
            acc_reg       <= 1'b0;
            ok_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            row_reg       <= row_next;
            board_reg     <= board_next;
            positions_reg <= positions_next;
            acc_reg       <= acc_next;
            ok_reg        <= ok_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        row_next       = row_reg;
        board_next     = board_reg;
        positions_next = positions_reg;
        acc_next       = acc_reg;
        ok_next        = ok_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    board_next = board;
                    row_next   = '0;
                    acc_next   = 1'b0;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (col_bus.col_ready) begin
                    positions_next[row_reg*COLW +: COLW] = cur_col;
                    acc_next = acc_reg | cur_err;
                    if (row_reg == LAST_ROW) begin
                        // Include the final row's error, which is not yet in acc_reg.
                        ok_next    = ~(acc_reg | cur_err);
                        state_next = DONE;
                    end else begin
                        row_next = row_reg + COLW'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign col_bus.col_valid = emit;
    assign col_bus.row_idx   = emit ? row_reg : '0;
    assign col_bus.col_idx   = emit ? cur_col : '0;
    assign col_bus.row_err   = emit & cur_err;

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign positions = positions_reg;
    assign board_ok  = ok_reg;

endmodule

// File: tb/tb_queen_board_encoder.sv
// Self-checking bench for queen_board_encoder: vector table, backpressure,
// start-while-busy, randomized boards against a row-rule model, async reset.
module tb_queen_board_encoder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] board = '0;
    logic        busy;
    logic        done;
    logic [23:0] positions;
    logic        board_ok;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] T1 = 64'h0802400420801001;
    localparam logic [63:0] T3 = 64'h0802240400801001;

    typedef struct {
        logic [63:0] brd;
        logic [23:0] pos;
        bit          ok;
    } vec_t;

    vec_t tab [4];

    queen_board_encoder_if cb ();

    queen_board_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .board     (board),
        .busy      (busy),
        .done      (done),
        .positions (positions),
        .board_ok  (board_ok),
        .col_bus   (cb.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: a row is good iff exactly one queen; its column is the first queen found.
    function automatic int ref_col(input logic [7:0] b);
        for (int c = 0; c < 8; c++) begin
            if (b[c]) return c;
        end
        return 0;
    endfunction

    function automatic bit ref_err(input logic [7:0] b);
        int n = 0;
        for (int c = 0; c < 8; c++) n += int'(b[c]);
        return n != 1;
    endfunction

    function automatic logic [23:0] ref_pos(input logic [63:0] b);
        logic [23:0] p = '0;
        for (int r = 0; r < 8; r++) p = p + (24'(ref_col(b[8*r +: 8])) << (3*r));
        return p;
    endfunction

    function automatic bit ref_ok(input logic [63:0] b);
        for (int r = 0; r < 8; r++) begin
            if (ref_err(b[8*r +: 8])) return 1'b0;
        end
        return 1'b1;
    endfunction

    // mode 0: ready always; 1: stall stall_n cycles on stall_row; 2: random ready
    task automatic scan(input logic [63:0] b, input int mode, input int stall_row,
                        input int stall_n, input bit inject, input string tag);
        logic [23:0] exp_pos;
        bit          exp_ok;
        int          row    = 0;
        int          cyc    = 0;
        int          stalls = 0;
        int          held   = 0;
        bit          rdy;
        exp_pos = ref_pos(b);
        exp_ok  = ref_ok(b);
        @(negedge clk);
        board = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (row < 8 && cyc < 400) begin
            chk("col_valid", 64'(cb.col_valid), 64'(1));
            chk("row_idx", 64'(cb.row_idx), 64'(row));
            chk("col_idx", 64'(cb.col_idx), 64'(ref_col(b[8*row +: 8])));
            chk("row_err", 64'(cb.row_err), 64'(ref_err(b[8*row +: 8])));
            chk("busy_emit", 64'(busy), 64'(1));
            chk("done_early", 64'(done), 64'(0));
            case (mode)
                1:       rdy = !(row == stall_row && held < stall_n);
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b1;
            endcase
            if (!rdy) begin
                held++;
                stalls++;
            end
            cb.col_ready = rdy;
            board = {$urandom, $urandom};
            if (inject && row == 4) begin
                start = 1'b1;
                board = ~b;
            end else begin
                start = 1'b0;
            end
            if (rdy) row++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("scan_bound", 64'(row), 64'(8));
        chk("done", 64'(done), 64'(1));
        chk("valid_in_done", 64'(cb.col_valid), 64'(0));
        chk("busy_done", 64'(busy), 64'(1));
        chk("latency", 64'(cyc), 64'(9 + stalls));
        chk("positions", 64'(positions), 64'(exp_pos));
        chk("board_ok", 64'(board_ok), 64'(exp_ok));
        $display("scan %s board=%016h positions=%06h board_ok=%0d cycles=%0d",
                 tag, b, positions, board_ok, cyc);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("positions_hold", 64'(positions), 64'(exp_pos));
        chk("board_ok_hold", 64'(board_ok), 64'(exp_ok));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_valid"}, 64'(cb.col_valid), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_ok"}, 64'(board_ok), 64'(0));
        chk({tag, "_row"}, 64'(cb.row_idx), 64'(0));
        chk({tag, "_col"}, 64'(cb.col_idx), 64'(0));
        chk({tag, "_err"}, 64'(cb.row_err), 64'(0));
        chk({tag, "_pos"}, 64'(positions), 64'(0));
    endtask

    initial begin
        logic [63:0] rb;
        tab[0] = '{brd: T1,                    pos: 24'h672BE0, ok: 1'b1};
        tab[1] = '{brd: T3,                    pos: 24'h6521E0, ok: 1'b0};
        tab[2] = '{brd: 64'h8040201008040201,  pos: 24'hFAC688, ok: 1'b1};
        tab[3] = '{brd: 64'h0,                 pos: 24'h000000, ok: 1'b0};

        cb.col_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            scan(tab[i].brd, 0, 0, 0, 1'b0, "table");
            chk("tab_positions", 64'(positions), 64'(tab[i].pos));
            chk("tab_board_ok", 64'(board_ok), 64'(tab[i].ok));
        end

        scan(T1, 1, 2, 3, 1'b0, "stall_row2");
        chk("stall_positions", 64'(positions), 64'h672BE0);

        scan(T1, 0, 0, 0, 1'b1, "start_while_busy");
        chk("busy_start_positions", 64'(positions), 64'h672BE0);
        scan(T3, 0, 0, 0, 1'b0, "rescan_bad");
        chk("rescan_board_ok", 64'(board_ok), 64'(0));

        for (int n = 0; n < 8; n++) begin
            for (int r = 0; r < 8; r++) begin
                if ($urandom_range(0, 5) == 0) rb[8*r +: 8] = 8'($urandom);
                else rb[8*r +: 8] = 8'(1) << $urandom_range(0, 7);
            end
            scan(rb, 2, 0, 0, 1'b0, "random");
        end

        // Abort at row 5 with an asynchronous reset mid-cycle.
        scan(T1, 0, 0, 0, 1'b0, "pre_reset");
        @(negedge clk);
        board = T1;
        start = 1'b1;
        cb.col_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && cb.row_idx != 3'd5; i++) @(negedge clk);
        chk("reach_row5", 64'(cb.row_idx), 64'(5));
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        repeat (3) begin
            @(negedge clk);
            chk("no_done_in_reset", 64'(done), 64'(0));
        end
        rst_n = 1'b1;
        scan(T1, 0, 0, 0, 1'b0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
